fadd_arbiter: RTL

FADD_ARBITER -- requirements
Module: fadd_arbiter

---
 rtl/fadd_arbiter_pkg.sv | 12 +
 rtl/fadd_arbiter_float_adder.sv | 88 ++++++++
 rtl/fadd_arbiter.sv | 83 ++++++++
 3 files changed

// File: rtl/fadd_arbiter_pkg.sv
// fadd_arbiter_pkg: shared float format (E_bit/F_bit/D_LEN), default adder latency
// and the requester-index width helper used by the arbiter and its adder.
package fadd_arbiter_pkg;
    localparam int E_bit = 8;
    localparam int F_bit = 23;
    localparam int D_LEN = E_bit + F_bit + 1;
    localparam int ADD_LAT_DEF = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fadd_arbiter_float_adder.sv
// float_adder: pipelined E_bit/F_bit float adder, round-to-nearest-even, subnormals
// flushed to zero; input register + align + add + normalise/round, LAT-4 extra delay.
module float_adder import fadd_arbiter_pkg::*; #(
    parameter int LAT = ADD_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [D_LEN-1:0] f_a,
    input  logic [D_LEN-1:0] f_b,
    output logic [D_LEN-1:0] adder_out
);
    localparam int M = F_bit + 1;
    localparam int EW = E_bit + 2;
    localparam int EMAX = (1 << E_bit) - 1;

    logic [D_LEN-1:0] ra, rb, res;
    logic [D_LEN-1:0] pipe [LAT-3];
    logic [D_LEN-2:0] mag_a, mag_b, lg, sm;
    logic             swap, s1_sgn, s1_sub, s2_sgn, s2_sub, rup, carry;
    logic [E_bit-1:0] d, dc, s1_e, s2_e;
    logic [2*M+1:0]   sh;
    logic [M-1:0]     s1_ml;
    logic [M+2:0]     s1_al, n;
    logic [M+3:0]     s2_sum;
    logic [EW-1:0]    lz, e, e2;
    logic [F_bit-1:0] frac;

    always_comb begin
        mag_a = (ra[D_LEN-2 -: E_bit] == '0) ? '0 : ra[D_LEN-2:0];
        mag_b = (rb[D_LEN-2 -: E_bit] == '0) ? '0 : rb[D_LEN-2:0];
        swap = mag_b > mag_a;
        lg = swap ? mag_b : mag_a;
        sm = swap ? mag_a : mag_b;
        d = lg[D_LEN-2 -: E_bit] - sm[D_LEN-2 -: E_bit];
        dc = (d > E_bit'(2*M+1)) ? E_bit'(2*M+1) : d;
        sh = {(sm[D_LEN-2 -: E_bit] != '0), sm[F_bit-1:0], {(M+2){1'b0}}} >> dc;
    end

    // Normalise: carry-out shifts right once, otherwise shift the leading one up to bit M+2.
    always_comb begin
        lz = '0;
        for (int i = 0; i <= M+2; i++)
            if (s2_sum[i]) lz = EW'(M+2-i);
        e = s2_sum[M+3] ? {2'b00, s2_e} + EW'(1) : {2'b00, s2_e} - lz;
        n = s2_sum[M+3] ? {s2_sum[M+3:2], |s2_sum[1:0]} : s2_sum[M+2:0] << lz;
        rup = n[2] & (n[1] | n[0] | n[3]);
        {carry, frac} = {1'b0, n[M+1:3]} + (F_bit+1)'(rup);
        e2 = e + EW'(carry);
        res = !n[M+2] ? {~s2_sub & s2_sgn, {(D_LEN-1){1'b0}}} :
              (e2[EW-1] || e2 == '0) ? {s2_sgn, {(D_LEN-1){1'b0}}} :
              (e2 >= EW'(EMAX)) ? {s2_sgn, {E_bit{1'b1}}, {F_bit{1'b0}}} :
              {s2_sgn, e2[E_bit-1:0], frac};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra <= '0;
            rb <= '0;
            s1_sgn <= 1'b0;
            s1_sub <= 1'b0;
            s1_e <= '0;
            s1_ml <= '0;
            s1_al <= '0;
            s2_sum <= '0;
            s2_e <= '0;
            s2_sgn <= 1'b0;
            s2_sub <= 1'b0;
            for (int i = 0; i < LAT-3; i++) pipe[i] <= '0;
        end else begin
            ra <= f_a;
            rb <= f_b;
            s1_sgn <= swap ? rb[D_LEN-1] : ra[D_LEN-1];
            s1_sub <= ra[D_LEN-1] ^ rb[D_LEN-1];
            s1_e <= lg[D_LEN-2 -: E_bit];
            s1_ml <= {(lg[D_LEN-2 -: E_bit] != '0), lg[F_bit-1:0]};
            s1_al <= {sh[2*M+1:M], |sh[M-1:0]};
            s2_sum <= s1_sub ? {1'b0, s1_ml, 3'b000} - {1'b0, s1_al}
                             : {1'b0, s1_ml, 3'b000} + {1'b0, s1_al};
            s2_e <= s1_e;
            s2_sgn <= s1_sgn;
            s2_sub <= s1_sub;
            pipe[0] <= res;
            for (int i = 1; i < LAT-3; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign adder_out = pipe[LAT-4];
endmodule

// File: rtl/fadd_arbiter.sv
// fadd_arbiter: NREQ-way round-robin arbiter feeding one pipelined float_adder.
// Define FADD_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead.
module fadd_arbiter import fadd_arbiter_pkg::*; #(
    parameter int NREQ = 4,
    parameter int ADD_LAT = ADD_LAT_DEF,
    localparam int IW = idx_w(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*D_LEN-1:0] req_a,
    input  logic [NREQ*D_LEN-1:0] req_b,
    output logic                  res_valid,
    output logic [IW-1:0]         res_id,
    output logic [D_LEN-1:0]      res_data,
    output logic                  busy
);
    localparam int CW = $clog2(ADD_LAT + 2);

    logic              xfer;
    logic [IW-1:0]     gnt_idx, base;
    logic [D_LEN-1:0]  iss_a, iss_b, adder_out;
    logic [ADD_LAT:0]  sr_v;
    logic [IW-1:0]     sr_id [ADD_LAT+1];
    logic [CW-1:0]     inflight;

`ifdef FADD_ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [IW-1:0] rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr <= '0;
        else if (xfer) rr_ptr <= gnt_idx + IW'(1);
    end

    assign base = rr_ptr;
`endif

    // Scan from the farthest candidate down so the nearest valid one after base wins.
    always_comb begin
        xfer = 1'b0;
        gnt_idx = '0;
        for (int k = NREQ-1; k >= 0; k--)
            if (req_valid[base + IW'(k)]) begin
                xfer = 1'b1;
                gnt_idx = base + IW'(k);
            end
        xfer = xfer & rst_n;
        req_ready = xfer ? NREQ'(1) << gnt_idx : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_a <= '0;
            iss_b <= '0;
            sr_v <= '0;
            for (int i = 0; i <= ADD_LAT; i++) sr_id[i] <= '0;
            inflight <= '0;
        end else begin
            iss_a <= xfer ? req_a[gnt_idx*D_LEN +: D_LEN] : '0;
            iss_b <= xfer ? req_b[gnt_idx*D_LEN +: D_LEN] : '0;
            sr_v <= {sr_v[ADD_LAT-1:0], xfer};
            sr_id[0] <= xfer ? gnt_idx : '0;
            for (int i = 1; i <= ADD_LAT; i++) sr_id[i] <= sr_id[i-1];
            inflight <= inflight + CW'(xfer) - CW'(res_valid);
        end
    end

    float_adder #(.LAT(ADD_LAT)) u_fadd (
        .clk       (clk),
        .rst_n     (rst_n),
        .f_a       (iss_a),
        .f_b       (iss_b),
        .adder_out (adder_out)
    );

    assign res_valid = sr_v[ADD_LAT];
    assign res_id = sr_id[ADD_LAT];
    assign res_data = res_valid ? adder_out : '0;
    assign busy = inflight != '0;
endmodule
